census_scan_ctrl: RTL and testbench
===================================

CENSUS_SCAN_CTRL -- requirements
Module: census_scan_ctrl

Interface
REQ-001 Parameter FRAME_WIDTH, default 400: pixels per row.
REQ-002 Parameter FRAME_HEIGHT, default 300: rows per frame, at most 1022.
REQ-003 Parameter PIXEL_DEPTH, default 8: pixel width in bits.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse that arms a frame.
REQ-007 s_data  in  PIXEL_DEPTH  source pixel.
REQ-008 s_valid  in  1  source pixel valid.
REQ-009 s_last  in  1  source end-of-frame marker, qualified by s_valid.
REQ-010 s_ready  out  1  controller accepts a pixel.
REQ-011 cen_data  out  PIXEL_DEPTH  pixel to the census window.
REQ-012 cen_en  out  1  shift enable to the census window.
REQ-013 cen_row  out  10  raster row of cen_data.
REQ-014 cen_col  out  10  raster column of cen_data.
REQ-015 busy  out  1  frame in progress (not IDLE).
REQ-016 frame_done  out  1  one-cycle pulse when the census pipeline has drained.
REQ-017 err_last  out  1  sticky s_last misalignment flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, STREAM, FLUSH and DRAIN.
REQ-019 IDLE->STREAM on start; row/col counters cleared to 0; err_last cleared.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 s_ready SHALL be 1 only in STREAM, combinational from state.
REQ-022 A transfer is s_valid & s_ready; per transfer: cen_en=1, cen_data=s_data, cen_row/cen_col=counter values, all registered (latency 1 cycle).
REQ-023 In cycles with no transfer, cen_en=0; cen_data/cen_row/cen_col SHALL hold their last values.
REQ-024 Column counter wraps FRAME_WIDTH-1 -> 0 and increments row; row does not wrap within a frame.
REQ-025 STREAM->FLUSH on the transfer at (FRAME_HEIGHT-1, FRAME_WIDTH-1) or on any transfer with s_last=1, whichever comes first.
REQ-026 err_last SHALL be set when s_last=1 on a transfer not at the final pixel, or when the final pixel transfers with s_last=0.
REQ-027 FLUSH SHALL issue FRAME_WIDTH+2 consecutive cen_en cycles with cen_data=0, continuing the raster row/col count, one per clock, no source handshake.
REQ-028 FLUSH->DRAIN after the last flush pixel; DRAIN lasts exactly 4 cycles with cen_en=0, then ->IDLE with frame_done=1 for one cycle.
REQ-029 Frame length from start to frame_done, with s_valid held high: 1 + W*H + (W+2) + 4 cycles.

Reset
REQ-030 On rst_n=0 the FSM SHALL enter IDLE immediately; s_ready, cen_en, busy, frame_done, err_last = 0; cen_data, cen_row, cen_col = 0; counters = 0.
REQ-031 Reset mid-frame SHALL abandon the frame without a frame_done pulse; release requires a new start.

Configuration
REQ-032 Macro CENSUS_SCAN_FLUSH_EN: defined -> FLUSH state behaves per REQ-027.
REQ-033 Without CENSUS_SCAN_FLUSH_EN: STREAM SHALL go directly to DRAIN; no zero pixels are issued.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the 10-bit coordinate type and the DRAIN length constant (4, equal to the census pipeline depth).
REQ-035 One sub-module census_raster_cnt SHALL implement the row/col counter with clear, increment and wrap.

Verification (W=4, H=3)
REQ-036 start, s_valid=1, 12 pixels 1..12, s_last on 12th -> cen_en high 12 cycles, rows 0,0,0,0,1..2, cols 0..3 repeated; then 6 zero flush pixels (row 3 col 0..3, row 4 col 0..1); frame_done 4 cycles after the last flush pixel; err_last=0.
REQ-037 s_valid toggled 1/0 every cycle -> cen_en mirrors transfers only; coordinates unchanged on idle cycles; no pixel lost.
REQ-038 s_last on pixel 7 -> FLUSH after pixel 7 at (1,2); err_last=1 until next start.
REQ-039 rst_n pulled low during FLUSH -> all outputs 0 same cycle; no frame_done; next start restarts at (0,0).
REQ-040 start pulsed during STREAM -> ignored, counters unaffected.
REQ-041 Build without CENSUS_SCAN_FLUSH_EN -> frame_done 4 cycles after pixel 12, no zero pixels.

Source files
------------

// File: rtl/census_scan_pkg.sv
// Shared types for the census scan controller.
// Holds the FSM states, the coordinate type and the drain depth.
package census_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DRAIN
  } scan_state_t;

  typedef logic [9:0] coord_t;

  localparam int DRAIN_LEN = 4;

endpackage

// File: rtl/census_raster_cnt.sv
// Raster row/column counter for the census scan controller.
// Column wraps at FRAME_WIDTH-1 and bumps the row; row never wraps.
module census_raster_cnt
  import census_scan_pkg::*;
#(
  parameter int FRAME_WIDTH = 400
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   inc,
  output coord_t row,
  output coord_t col
);

  localparam coord_t COL_LAST = coord_t'(FRAME_WIDTH - 1);

  // clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + coord_t'(1);
      end else begin
        col <= col + coord_t'(1);
      end
    end
  end

endmodule

// File: rtl/census_scan_ctrl.sv
// Census window scan controller: streams a frame, flushes, drains.
// CENSUS_SCAN_FLUSH_EN adds W+2 trailing zero pixels before drain.
module census_scan_ctrl
  import census_scan_pkg::*;
#(
  parameter int FRAME_WIDTH  = 400,
  parameter int FRAME_HEIGHT = 300,
  parameter int PIXEL_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PIXEL_DEPTH-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [PIXEL_DEPTH-1:0] cen_data,
  output logic                   cen_en,
  output logic [9:0]             cen_row,
  output logic [9:0]             cen_col,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_last
);

  localparam int PW = $clog2(FRAME_WIDTH + 3) + 1;
  localparam coord_t ROW_LAST = coord_t'(FRAME_HEIGHT - 1);
  localparam coord_t COL_LAST = coord_t'(FRAME_WIDTH - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_LEN - 1);
`ifdef CENSUS_SCAN_FLUSH_EN
  localparam logic [PW-1:0] FLUSH_LAST = PW'(FRAME_WIDTH + 1);
`endif

  scan_state_t state, nxt;
  logic [PW-1:0] phase;
  coord_t row, col;
  logic xfer, at_final, flush_pix;
  logic cnt_clr, done_set;

  assign s_ready   = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign xfer      = s_valid & s_ready;
  assign flush_pix = (state == S_FLUSH);
  assign at_final  = (row == ROW_LAST) && (col == COL_LAST);

  census_raster_cnt #(
    .FRAME_WIDTH(FRAME_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (xfer | flush_pix),
    .row  (row),
    .col  (col)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state and frame control
  always_comb begin
    nxt      = state;
    cnt_clr  = 1'b0;
    done_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nxt     = S_STREAM;
          cnt_clr = 1'b1;
        end
      end
      S_STREAM: begin
        if (xfer && (at_final || s_last)) begin
`ifdef CENSUS_SCAN_FLUSH_EN
          nxt = S_FLUSH;
`else
          nxt = S_DRAIN;
`endif
        end
      end
      S_FLUSH: begin
`ifdef CENSUS_SCAN_FLUSH_EN
        if (phase == FLUSH_LAST) nxt = S_DRAIN;
`else
        nxt = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        if (phase == DRAIN_LAST) begin
          nxt      = S_IDLE;
          done_set = 1'b1;
        end
      end
    endcase
  end

  // per-state cycle counter for flush and drain lengths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                phase <= '0;
    else if (nxt != state)     phase <= '0;
    else if (state == S_FLUSH
          || state == S_DRAIN) phase <= phase + PW'(1);
  end

  // census window outputs, held when nothing is shifted in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_en   <= 1'b0;
      cen_data <= '0;
      cen_row  <= '0;
      cen_col  <= '0;
    end else begin
      cen_en <= xfer | flush_pix;
      if (xfer) begin
        cen_data <= s_data;
        cen_row  <= row;
        cen_col  <= col;
      end else if (flush_pix) begin
        cen_data <= '0;
        cen_row  <= row;
        cen_col  <= col;
      end
    end
  end

  // done pulse and sticky end-of-frame misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      err_last   <= 1'b0;
    end else begin
      frame_done <= done_set;
      if (state == S_IDLE && start)
        err_last <= 1'b0;
      else if (xfer && (s_last != at_final))
        err_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_census_scan_ctrl.sv
// Bench for census_scan_ctrl at W=4, H=3.
// Frame scenarios from a table; expectations from raster arithmetic.
module tb_census_scan_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 8;
  localparam int DR = 4;
`ifdef CENSUS_SCAN_FLUSH_EN
  localparam int F = W + 2;
`else
  localparam int F = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [D-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [D-1:0] cen_data;
  logic         cen_en;
  logic [9:0]   cen_row;
  logic [9:0]   cen_col;
  logic         busy;
  logic         frame_done;
  logic         err_last;

  census_scan_ctrl #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .PIXEL_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .cen_data  (cen_data),
    .cen_en    (cen_en),
    .cen_row   (cen_row),
    .cen_col   (cen_col),
    .busy      (busy),
    .frame_done(frame_done),
    .err_last  (err_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int h_data, h_row, h_col;

  typedef struct {
    int mode;
    int last_at;
    int start_mid;
    bit exp_err;
    int exp_n;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_en"},    cen_en,     0);
    chk({tag, "_data"},  cen_data,   0);
    chk({tag, "_row"},   cen_row,    0);
    chk({tag, "_col"},   cen_col,    0);
    chk({tag, "_busy"},  busy,       0);
    chk({tag, "_ready"}, s_ready,    0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_err"},   err_last,   0);
  endtask

  task automatic run_frame(input vec_t v);
    int k, e, n, cnt_en, idx, exp_en;
    bit ve, finished;
    logic [D-1:0] d;
    start   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    start = 1'b0;
    chk("arm_busy",  busy,    1);
    chk("arm_ready", s_ready, 1);
    chk("arm_en",    cen_en,  0);
    chk("arm_err",   err_last, 0);
    k = 0; e = -1; n = 0; cnt_en = 0; finished = 1'b0;
    for (int c = 1; c < 300; c++) begin
      case (v.mode)
        0:       ve = 1'b1;
        1:       ve = c[0];
        default: ve = 1'($urandom_range(0, 1));
      endcase
      d       = D'($urandom);
      start   = (c == v.start_mid);
      s_valid = ve;
      s_data  = d;
      s_last  = ve && (e < 0) && (k == v.last_at);
      exp_en  = 0;
      if (e < 0 && ve) begin
        exp_en = 1;
        h_data = d;
        h_row  = k / W;
        h_col  = k % W;
        if (k == v.last_at || k == W * H - 1) begin
          e = c;
          n = k + 1;
        end
        k++;
      end else if (e >= 0 && c <= e + F) begin
        idx    = n + c - e - 1;
        exp_en = 1;
        h_data = 0;
        h_row  = idx / W;
        h_col  = idx % W;
      end
      tick();
      if (cen_en) cnt_en++;
      chk("cen_en",   cen_en,   exp_en);
      chk("cen_data", cen_data, h_data);
      chk("cen_row",  cen_row,  h_row);
      chk("cen_col",  cen_col,  h_col);
      chk("s_ready",  s_ready,  (e < 0) ? 1 : 0);
      chk("err_last", err_last, (e >= 0) ? int'(v.exp_err) : 0);
      chk("frame_done", frame_done,
          (e >= 0 && c == e + F + DR) ? 1 : 0);
      chk("busy", busy, (e >= 0 && c >= e + F + DR) ? 0 : 1);
      if (e >= 0 && c == e + F + DR) begin
        finished = 1'b1;
        break;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL frame_end: got no end want end");
    end
    chk("n_pix", cnt_en, v.exp_n + F);
    tick();
    chk("done_once", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err",  err_last, int'(v.exp_err));
  endtask

  initial begin
    tbl[0] = '{0, 11, -1, 1'b0, 12};
    tbl[1] = '{1, 11, -1, 1'b0, 12};
    tbl[2] = '{0,  6, -1, 1'b1,  7};
    tbl[3] = '{2, 99, -1, 1'b1, 12};
    tbl[4] = '{0, 11,  3, 1'b0, 12};
    tbl[5] = '{2, 11, -1, 1'b0, 12};
    tbl[6] = '{2,  0,  5, 1'b1,  1};

    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    h_data  = 0;
    h_row   = 0;
    h_col   = 0;
    repeat (3) tick();
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    start = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s_data = D'(i + 1);
      s_last = (i == 11);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("abort");
    #1;
    rst_n  = 1'b1;
    h_data = 0;
    h_row  = 0;
    h_col  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_done", frame_done, 0);
      chk("abort_busy", busy, 0);
    end

    run_frame(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
